// File: rtl/wb_trace_buffer_pkg.sv
// rtl/wb_trace_buffer_pkg.sv - shared trace state encodings and entry layout
package wb_trace_buffer_pkg;

  // Capture state machine encodings
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ARMED     = 2'd1;
  localparam logic [1:0] CAPTURING = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  // Writeback field widths
  localparam int TRACE_RD_BITS   = 5;
  localparam int TRACE_DATA_BITS = 32;

  // Packed entry layout {pc, rd, data}, data in the LSBs
  localparam int TRACE_DATA_LSB = 0;
  localparam int TRACE_RD_LSB   = TRACE_DATA_LSB + TRACE_DATA_BITS;
  localparam int TRACE_PC_LSB   = TRACE_RD_LSB + TRACE_RD_BITS;

  // Total entry width for a given PC width
  function automatic int trace_entry_bits(input int address_bits);
    return address_bits + TRACE_PC_LSB;
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// rtl/wb_trace_buffer_if.sv - writeback input and trace drain bundle
interface wb_trace_buffer_if
  import wb_trace_buffer_pkg::*;
#(
  parameter int ADDRESS_BITS = 16
);

  logic                                          wb_valid;
  logic [ADDRESS_BITS-1:0]                       wb_pc;
  logic [TRACE_RD_BITS-1:0]                      wb_rd;
  logic [TRACE_DATA_BITS-1:0]                    wb_data;
  logic                                          trace_valid;
  logic                                          trace_ready;
  logic [trace_entry_bits(ADDRESS_BITS)-1:0]     trace_data;

  // Environment side: drives writebacks, sinks the trace stream
  modport master (
    output wb_valid, wb_pc, wb_rd, wb_data, trace_ready,
    input  trace_valid, trace_data
  );

  // Trace buffer side
  modport slave (
    input  wb_valid, wb_pc, wb_rd, wb_data, trace_ready,
    output trace_valid, trace_data
  );

endinterface

// File: rtl/wb_trace_buffer_sync_fifo.sv
// rtl/wb_trace_buffer_sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH    = 53,
  parameter int DEPTH    = 16,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_BITS:0] occupancy
);

  localparam logic [PTR_BITS:0]   FULL_COUNT = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS:0]   CNT_ONE    = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_BITS-1:0] PTR_ONE    = {{(PTR_BITS - 1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                do_push;
  logic                do_pop;

  assign full      = (count == FULL_COUNT);
  assign empty     = (count == '0);
  assign occupancy = count;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is read straight from storage; forced to zero when nothing is held
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because the output is gated by empty
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// rtl/wb_trace_buffer.sv - PC-triggered writeback trace capture with drain port
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int DEPTH        = 16,
  parameter int PTR_BITS     = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  wb_trace_buffer_if.slave        bus,
  input  logic                    arm,
  input  logic [ADDRESS_BITS-1:0] trigger_pc,
  input  logic [PTR_BITS:0]       post_count,
  output logic [PTR_BITS:0]       occupancy,
  output logic                    overflow,
  output logic                    done
);

  localparam int                ENTRY_BITS = trace_entry_bits(ADDRESS_BITS);
  localparam logic [PTR_BITS:0] CNT_ONE    = {{PTR_BITS{1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [PTR_BITS:0]     remain;
  logic [PTR_BITS:0]     remain_init;
  logic                  trigger_hit;
  logic                  capture;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_BITS-1:0] entry;
  logic [ENTRY_BITS-1:0] head;

  assign entry       = {bus.wb_pc, bus.wb_rd, bus.wb_data};
  assign trigger_hit = (state == ARMED) && (bus.wb_pc == trigger_pc);
  // Dropping arm wins over everything, including a same-cycle writeback
  assign capture     = arm && bus.wb_valid && (trigger_hit || (state == CAPTURING));
  assign pop         = !fifo_empty && bus.trace_ready;
  // The trigger entry itself counts, so a post_count of 0 still captures one
  assign remain_init = (post_count == '0) ? '0 : post_count - CNT_ONE;

  assign bus.trace_valid = !fifo_empty;
  assign bus.trace_data  = head;
  assign done            = (state == DONE);

  sync_fifo #(
    .WIDTH    (ENTRY_BITS),
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (capture),
    .push_data (entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // Capture state machine and remaining-entry counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      remain <= '0;
    end else if (!arm) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state  <= ARMED;
          remain <= '0;
        end
        ARMED: begin
          if (capture) begin
            remain <= remain_init;
            state  <= (remain_init == '0) ? DONE : CAPTURING;
          end
        end
        CAPTURING: begin
          if (capture) begin
            remain <= remain - CNT_ONE;
            if (remain <= CNT_ONE) begin
              state <= DONE;
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // Sticky overflow: set when a capture finds no free slot, cleared on arming
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (arm && (state == IDLE)) begin
      overflow <= 1'b0;
    end else if (capture && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule
